xs_gfx_rom_arbiter: RTL
=======================

// Module: xs_gfx_rom_arbiter
// PURPOSE
//  Shares one synchronous graphics ROM read port (BRAM/SDRAM bridge) among NREQ tile-fetch
//  requesters (MAP, BG, FG, OBJ layers). Round-robin grant, one outstanding access, per-requester
//  valid/ready request and single-cycle response pulse. Sits between layer fetch logic and ROM.
//  Yields the port to the ROM loader while load_active is high.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  ADDR_W   20  ROM byte address width
//  DATA_W   8   ROM data width
//  MEM_LAT  2   ROM read latency: cycles from mem_addr/mem_cs registered to mem_q valid (>=1)
// PORTS
//  clk          in   1              master clock, all logic on rising edge
//  RESETn       in   1              asynchronous active-low reset
//  load_active  in   1              ROM loader owns port; blocks new grants
//  req_valid    in   NREQ           request i pending; held with req_addr until req_ready[i] seen
//  req_addr     in   NREQ*ADDR_W    requester i address at [i*ADDR_W +: ADDR_W]
//  req_ready    out  NREQ           one-cycle pulse: request i accepted
//  rsp_valid    out  NREQ           one-cycle pulse: rsp_data belongs to requester i
//  rsp_data     out  DATA_W         read data, stable until next rsp_valid
//  mem_cs       out  1              ROM port enable, high during access
//  mem_addr     out  ADDR_W         ROM address
//  mem_q        in   DATA_W         ROM data
// BEHAVIOUR
//  Reset: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, mem_cs=0, mem_addr=0, rr_last=NREQ-1.
//  All outputs registered. States: IDLE, WAIT, RESP.
//  IDLE: if !load_active and any req_valid: pick first valid index scanning rr_last+1..rr_last
//   (mod NREQ); at edge E0 register mem_addr<=req_addr[g], mem_cs<=1, req_ready[g]<=1 (1 cycle),
//   gnt<=g, rr_last<=g, cnt<=0, ->WAIT. No valid or load_active: stay, mem_cs=0.
//  WAIT: cnt increments each cycle; when cnt==MEM_LAT-1 capture rsp_data<=mem_q, rsp_valid[gnt]<=1,
//   mem_cs<=0, ->RESP. cnt width $clog2(MEM_LAT+1).
//  RESP: rsp_valid cleared, ->IDLE. Access period MEM_LAT+2 cycles; rsp_valid visible after edge
//   E0+MEM_LAT. Requester must drop or change req_valid/req_addr upon seeing req_ready.
//  load_active rising during WAIT/RESP: in-flight access completes normally; no new grant after.
//  Simultaneous valid on all: grants rotate 0,1,..,NREQ-1,0 with no starvation.
//  req_valid dropped before grant: request ignored, no ready/rsp issued.
//  RESETn low mid-access: immediate return to reset values; pending response discarded.
// CONFIGURATION
//  XS_ROMARB_LASTHIT_EN defined: per-requester tag/data/valid register. In IDLE, if selected g has
//   hit (tag==req_addr[g] and tag_valid), edge E0 sets req_ready[g], E0+1 sets rsp_valid[g] with
//   cached data, no mem_cs; ->RESP directly. Miss fills tag/data at capture. load_active high
//   clears all tag_valid. Undefined: every request accesses ROM; no cache registers.
// STRUCTURE
//  Package xs_romarb_pkg: state enum typedef (IDLE/WAIT/RESP), default parameter constants.
//  Sub-module xs_rr_picker: combinational round-robin priority picker (valid vector, last index
//   -> grant index + any flag); reusable by other arbiters in the core.
// TESTING
//  1 single: MEM_LAT=2, req_valid=4'b0001 addr 0x01234, mem model q=addr[7:0] -> ready[0] one cycle,
//    rsp_valid[0] 2 edges later with rsp_data 0x34, mem_cs high exactly 2 cycles.
//  2 fairness: all 4 valid continuously (re-asserted after ready) -> grant order 0,1,2,3,0,1 and
//    one access every 4 cycles.
//  3 loader: load_active=1 with req_valid=4'b0100 -> no mem_cs/ready; drop load_active -> grant 2.
//  4 reset: assert RESETn low during WAIT -> no rsp_valid ever; after release first grant is req 0.
//  5 load mid-access: load_active rises in WAIT -> in-flight rsp delivered, then no further grant.
//  6 LASTHIT_EN: req1 reads 0x00100 twice -> second response 1 cycle after ready, mem_cs stays 0;
//    pulse load_active then repeat -> memory access occurs again.

Source files
------------

// File: rtl/xs_romarb_pkg.sv
// xs_romarb_pkg: shared types and default constants for the graphics ROM arbiter.
//   - default parameter values (requester count, address/data width, ROM latency)
//   - FSM state encodings as plain constants plus an enum typedef built on them
package xs_romarb_pkg;

  localparam int ROMARB_NREQ    = 4;
  localparam int ROMARB_ADDR_W  = 20;
  localparam int ROMARB_DATA_W  = 8;
  localparam int ROMARB_MEM_LAT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } romarb_state_e;

endpackage

// File: rtl/xs_rr_picker.sv
// xs_rr_picker: combinational round-robin priority picker.
//   i_valid [N]  request vector
//   i_last  [IW] index granted last time
//   o_gnt   [IW] first valid index scanning i_last+1 .. i_last (mod N)
//   o_any        at least one request valid
module xs_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_gnt,
  output logic          o_any
);

  // Scan from lowest priority to highest so the last hit written wins;
  // avoids a break and keeps the loop a plain priority mux.
  always_comb begin
    o_gnt = '0;
    o_any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(i_last) + k) % N;
      if (i_valid[idx]) begin
        o_gnt = IW'(idx);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xs_gfx_rom_arbiter.sv
// xs_gfx_rom_arbiter: shares one synchronous graphics ROM read port among NREQ
// tile-fetch requesters. Round-robin grant, one access in flight, per-requester
// valid/ready request and one-cycle response pulse. New grants are held off
// while the ROM loader owns the port (load_active).
// Ports:
//   clk, RESETn (async, active low)
//   load_active            loader owns the ROM port
//   req_valid/req_addr     per-requester request, addr i at [i*ADDR_W +: ADDR_W]
//   req_ready              one-cycle accept pulse
//   rsp_valid/rsp_data     one-cycle response pulse, data held until next response
//   mem_cs/mem_addr/mem_q  ROM port, mem_q valid MEM_LAT cycles after mem_addr
// Optional: XS_ROMARB_LASTHIT_EN adds a one-entry last-hit cache per requester;
// a hit answers from the cache without touching the ROM.
module xs_gfx_rom_arbiter
  import xs_romarb_pkg::*;
#(
  parameter int NREQ    = ROMARB_NREQ,
  parameter int ADDR_W  = ROMARB_ADDR_W,
  parameter int DATA_W  = ROMARB_DATA_W,
  parameter int MEM_LAT = ROMARB_MEM_LAT
) (
  input  logic                   clk,
  input  logic                   RESETn,
  input  logic                   load_active,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   mem_cs,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_q
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MEM_LAT + 1);

  romarb_state_e     r_state;
  logic [IW-1:0]     r_gnt, r_last;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_ready, r_rsp;
  logic [DATA_W-1:0] r_data;
  logic              r_cs;
  logic [ADDR_W-1:0] r_addr;

  logic [IW-1:0]     w_gnt;
  logic              w_any;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_cap;

  xs_rr_picker #(.N(NREQ), .IW(IW)) u_pick (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_any   (w_any)
  );

  assign w_sel_addr = req_addr[w_gnt*ADDR_W +: ADDR_W];

`ifdef XS_ROMARB_LASTHIT_EN
  logic [NREQ-1:0][ADDR_W-1:0] r_tag;
  logic [NREQ-1:0][DATA_W-1:0] r_cdata;
  logic [NREQ-1:0]             r_tvld;
  logic                        r_hit;   // current grant is served from cache
  logic                        w_hit;

  assign w_hit = r_tvld[w_gnt] && (r_tag[w_gnt] == w_sel_addr);
  assign w_cap = (r_state == S_WAIT) && !r_hit && (r_cnt == CW'(MEM_LAT - 1));

  // Fill on every ROM capture; the loader may rewrite ROM, so any loader
  // activity invalidates everything (clear wins over a same-cycle fill).
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_tag   <= '0;
      r_cdata <= '0;
      r_tvld  <= '0;
    end else begin
      if (w_cap) begin
        r_tag[r_gnt]   <= r_addr;
        r_cdata[r_gnt] <= mem_q;
        r_tvld[r_gnt]  <= 1'b1;
      end
      if (load_active) r_tvld <= '0;
    end
  end
`else
  assign w_cap = (r_state == S_WAIT) && (r_cnt == CW'(MEM_LAT - 1));
`endif

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_last  <= IW'(NREQ - 1);
      r_cnt   <= '0;
      r_ready <= '0;
      r_rsp   <= '0;
      r_data  <= '0;
      r_cs    <= 1'b0;
      r_addr  <= '0;
`ifdef XS_ROMARB_LASTHIT_EN
      r_hit   <= 1'b0;
`endif
    end else begin
      r_ready <= '0;
      case (r_state)
        S_IDLE: begin
          r_cs <= 1'b0;
          if (!load_active && w_any) begin
            r_ready[w_gnt] <= 1'b1;
            r_gnt          <= w_gnt;
            r_last         <= w_gnt;
            r_cnt          <= '0;
            r_state        <= S_WAIT;
`ifdef XS_ROMARB_LASTHIT_EN
            r_hit <= w_hit;
            if (!w_hit) begin
              r_addr <= w_sel_addr;
              r_cs   <= 1'b1;
            end
`else
            r_addr <= w_sel_addr;
            r_cs   <= 1'b1;
`endif
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
`ifdef XS_ROMARB_LASTHIT_EN
          // Hit: one pass through WAIT, answer with cached data.
          if (r_hit) begin
            r_data       <= r_cdata[r_gnt];
            r_rsp[r_gnt] <= 1'b1;
            r_state      <= S_RESP;
          end
`endif
          if (w_cap) begin
            r_data       <= mem_q;
            r_rsp[r_gnt] <= 1'b1;
            r_cs         <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp;
  assign rsp_data  = r_data;
  assign mem_cs    = r_cs;
  assign mem_addr  = r_addr;

endmodule
